// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with branch/jump resolution, stall-pending redirect and exception entry
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] pc_d,
    input  logic [2:0]  npc_op,
    input  logic [2:0]  br_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic        pend_valid,
    output logic        addr_err
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend_tgt;
    logic [31:0] w_pend_tgt_nxt;
    logic        r_addr_err;
    logic        w_addr_err_nxt;

    logic [31:0] w_pc_d_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic [31:0] w_load_tgt;
    logic        w_taken;
    logic        w_redirect;

    assign w_pc_d_plus4 = pc_d + 32'd4;
    assign w_br_target  = w_pc_d_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign w_j_target   = {w_pc_d_plus4[31:28], instr_index, 2'b00};

    always_comb begin
        w_taken = 1'b0;
        case (br_op)
            3'd0:    w_taken = (rs_val == rt_val);
            3'd1:    w_taken = (rs_val != rt_val);
            3'd2:    w_taken = ($signed(rs_val) <= 32'sd0);
            3'd3:    w_taken = ($signed(rs_val) >  32'sd0);
            3'd4:    w_taken = ($signed(rs_val) <  32'sd0);
            3'd5:    w_taken = ($signed(rs_val) >= 32'sd0);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_redirect = 1'b0;
        w_target   = w_j_target;
        case (npc_op)
            3'd1: begin
                w_redirect = w_taken;
                w_target   = w_br_target;
            end
            3'd2, 3'd3: w_redirect = 1'b1;
            3'd4: begin
                w_redirect = 1'b1;
                w_target   = rs_val;
            end
            default: w_redirect = 1'b0;
        endcase
    end

    // Pending target has priority over a fresh redirect on the unstall edge
    assign w_load_tgt = (r_state == PEND) ? r_pend_tgt : w_target;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_tgt_nxt = r_pend_tgt;
        w_addr_err_nxt = 1'b0;
        if (exc_req) begin
            w_pc_nxt    = EXC_VECTOR;
            w_state_nxt = RUN;
        end else if (eret) begin
            w_pc_nxt    = epc;
            w_state_nxt = RUN;
        end else if (stall) begin
            if (w_redirect) begin
                w_pend_tgt_nxt = w_target;
                w_state_nxt    = PEND;
            end
        end else if ((r_state == PEND) || w_redirect) begin
            w_state_nxt = RUN;
            // Misaligned targets trap to the exception vector instead of being fetched
            if (w_load_tgt[1:0] != 2'b00) begin
                w_pc_nxt       = EXC_VECTOR;
                w_addr_err_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_load_tgt;
            end
        end else begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    assign pc         = r_pc;
    assign pend_valid = (r_state == PEND);
    assign addr_err   = r_addr_err;
    assign redirect   = w_redirect;
    assign link_addr  = pc_d + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized self-checking bench for pc_gen against a behavioural next-PC model
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_V  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc_d;
    logic [2:0]  npc_op;
    logic [2:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect;
    logic        pend_valid;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_err;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_d(pc_d), .npc_op(npc_op),
        .br_op(br_op), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
        .instr_index(instr_index), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .link_addr(link_addr), .redirect(redirect),
        .pend_valid(pend_valid), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic m_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(a);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_redirect();
        if (npc_op == 3'd1) return m_taken(br_op, rs_val, rt_val);
        return (npc_op >= 3'd2) && (npc_op <= 3'd4);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] off;
        off = {{16{imm16[15]}}, imm16};
        if (npc_op == 3'd1) return pc_d + 32'd4 + off * 32'd4;
        if (npc_op == 3'd4) return rs_val;
        return ((pc_d + 32'd4) & 32'hF000_0000) | (32'(instr_index) * 32'd4);
    endfunction

    task automatic idle_inputs();
        stall = 0; pc_d = 0; npc_op = 0; br_op = 0; rs_val = 0; rt_val = 0;
        imm16 = 0; instr_index = 0; exc_req = 0; eret = 0; epc = 0;
    endtask

    // Advance the model with the current inputs, clock the DUT, settle
    task automatic step();
        logic        r;
        logic [31:0] t;
        r = m_redirect();
        t = m_target();
        if (exc_req) begin
            m_pc = EXC_V; m_pend = 0; m_err = 0;
        end else if (eret) begin
            m_pc = epc; m_pend = 0; m_err = 0;
        end else if (stall) begin
            m_err = 0;
            if (r) begin m_pend = 1; m_tgt = t; end
        end else if (m_pend || r) begin
            if (m_pend) t = m_tgt;
            m_pend = 0;
            if (t % 4 != 0) begin m_pc = EXC_V; m_err = 1; end
            else begin m_pc = t; m_err = 0; end
        end else begin
            m_pc = m_pc + 32'd4; m_err = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        m_pc = RST_PC; m_pend = 0; m_tgt = 0; m_err = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        step(); step();
        reset = 1;
        #1;
        m_pc = RST_PC; m_pend = 0; m_tgt = 0; m_err = 0;
        total++;
        if (pc !== RST_PC) begin bad++; $display("FAIL reset_async_pc got=%h exp=%h", pc, RST_PC); end
        total++;
        if (pend_valid !== 1'b0 || addr_err !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b exp=00", pend_valid, addr_err);
        end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h3004, 32'h3008, 32'h300C};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (pc !== exp_seq[i]) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
        end
    endtask

    task automatic test_branch();
        pc_d = 32'h3010; npc_op = 1; br_op = 0; rs_val = 5; rt_val = 5; imm16 = 16'hFFFE;
        #1;
        total++;
        if (redirect !== 1'b1) begin bad++; $display("FAIL beq_redirect got=%b exp=1", redirect); end
        total++;
        if (link_addr !== 32'h3018) begin bad++; $display("FAIL beq_link got=%h exp=00003018", link_addr); end
        step();
        total++;
        if (pc !== 32'h300C) begin bad++; $display("FAIL beq_pc got=%h exp=0000300c", pc); end
        idle_inputs();
    endtask

    task automatic test_stall_pending();
        stall = 1; npc_op = 3; instr_index = 26'h000C40; pc_d = 32'h3000;
        step();
        total++;
        if (pc !== 32'h300C || pend_valid !== 1'b1) begin
            bad++; $display("FAIL stall_hold got pc=%h pv=%b exp pc=0000300c pv=1", pc, pend_valid);
        end
        instr_index = 26'h000D00;
        step();
        total++;
        if (pend_valid !== 1'b1) begin bad++; $display("FAIL stall_overwrite_pv got=%b exp=1", pend_valid); end
        stall = 0; npc_op = 2; instr_index = 26'h000E00;
        step();
        total++;
        if (pc !== 32'h3400 || pend_valid !== 1'b0) begin
            bad++; $display("FAIL pend_load got pc=%h pv=%b exp pc=00003400 pv=0", pc, pend_valid);
        end
        idle_inputs();
        do_reset();
        stall = 1; npc_op = 3; instr_index = 26'h000C40;
        step();
        stall = 0; npc_op = 0;
        step();
        total++;
        if (pc !== 32'h3100 || pend_valid !== 1'b0) begin
            bad++; $display("FAIL jal_unstall got pc=%h pv=%b exp pc=00003100 pv=0", pc, pend_valid);
        end
    endtask

    task automatic test_jr_misaligned();
        npc_op = 4; rs_val = 32'h0000_3002;
        step();
        total++;
        if (pc !== EXC_V || addr_err !== 1'b1) begin
            bad++; $display("FAIL jr_trap got pc=%h err=%b exp pc=%h err=1", pc, addr_err, EXC_V);
        end
        idle_inputs();
        step();
        total++;
        if (addr_err !== 1'b0 || pc !== 32'h4184) begin
            bad++; $display("FAIL jr_err_pulse got pc=%h err=%b exp pc=00004184 err=0", pc, addr_err);
        end
        stall = 1; npc_op = 4; rs_val = 32'h0000_5001;
        step();
        total++;
        if (addr_err !== 1'b0 || pc !== 32'h4184) begin
            bad++; $display("FAIL jr_stalled_no_trap got pc=%h err=%b", pc, addr_err);
        end
        exc_req = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_exc_eret();
        stall = 1; npc_op = 2; instr_index = 26'h1000;
        step();
        exc_req = 1; eret = 1; epc = 32'h3020; npc_op = 0;
        step();
        total++;
        if (pc !== EXC_V || pend_valid !== 1'b0) begin
            bad++; $display("FAIL exc_wins got pc=%h pv=%b exp pc=%h pv=0", pc, pend_valid, EXC_V);
        end
        exc_req = 0;
        step();
        total++;
        if (pc !== 32'h3020) begin bad++; $display("FAIL eret_pc got=%h exp=00003020", pc); end
        idle_inputs();
    endtask

    task automatic test_branch_conditions();
        npc_op = 1; br_op = 2; rs_val = 32'h8000_0000; pc_d = 32'h3020; imm16 = 16'h0010;
        #1;
        total++;
        if (redirect !== 1'b1) begin bad++; $display("FAIL blez_neg got=%b exp=1", redirect); end
        br_op = 3; rs_val = 0;
        #1;
        total++;
        if (redirect !== 1'b0) begin bad++; $display("FAIL bgtz_zero got=%b exp=0", redirect); end
        step();
        total++;
        if (pc !== m_pc) begin bad++; $display("FAIL bgtz_seq_pc got=%h exp=%h", pc, m_pc); end
        br_op = 6; rs_val = 1; rt_val = 1;
        #1;
        total++;
        if (redirect !== 1'b0) begin bad++; $display("FAIL br_op6 got=%b exp=0", redirect); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        npc_op = 4; rs_val = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        total++;
        if (pc !== 32'h0000_0000) begin bad++; $display("FAIL pc_wrap got=%h exp=00000000", pc); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            pc_d        = $urandom & 32'hFFFF_FFFC;
            npc_op      = 3'($urandom_range(0, 7));
            br_op       = 3'($urandom_range(0, 7));
            rs_val      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
            rt_val      = ($urandom_range(0, 1) == 0) ? rs_val : $urandom;
            imm16       = 16'($urandom);
            instr_index = 26'($urandom);
            exc_req     = ($urandom_range(0, 19) == 0);
            eret        = ($urandom_range(0, 19) == 0);
            epc         = $urandom;
            #1;
            total++;
            if (redirect !== m_redirect() || link_addr !== pc_d + 32'd8) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_comb[%0d] got red=%b link=%h exp red=%b link=%h",
                                        i, redirect, link_addr, m_redirect(), pc_d + 32'd8);
            end
            step();
            total++;
            if (pc !== m_pc || pend_valid !== m_pend || addr_err !== m_err) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_state[%0d] got pc=%h pv=%b err=%b exp pc=%h pv=%b err=%b",
                                        i, pc, pend_valid, addr_err, m_pc, m_pend, m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m_pc = RST_PC; m_pend = 0; m_tgt = 0; m_err = 0;
        #12;
        reset = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_pending();
        test_jr_misaligned();
        test_exc_eret();
        test_branch_conditions();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
